// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with ready handshake and watchdog
// Optional performance counters are compiled in with `define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int MAX_CPU_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic [31:0]       dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       dbg_grant_cnt_o,
`endif
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i
);

    localparam int RUN_W = (MAX_CPU_RUN < 1) ? 1 : $clog2(MAX_CPU_RUN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_dbg_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [RUN_W-1:0]    run_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [31:0]         cpu_rdata_q;
    logic [31:0]         dbg_rdata_q;
    logic                mem_en_q;
    logic                cpu_ack_q;
    logic                dbg_ack_q;
    logic                err_q;

    logic                grant_d;
    logic                pick_dbg_d;
    logic [RUN_W-1:0]    run_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_d;
    logic                tmo_hit;

    // The CPU wins ties until it has starved a waiting debug request RUN_MAX times.
    always_comb begin
        grant_d    = (state_q == S_IDLE) && start_i && (cpu_req_i || dbg_req_i);
        pick_dbg_d = dbg_req_i && (!cpu_req_i || (run_q == RUN_MAX));
        run_d      = '0;
        if (!pick_dbg_d && dbg_req_i) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end
        we_d    = pick_dbg_d ? dbg_we_i                   : cpu_we_i;
        addr_d  = pick_dbg_d ? dbg_addr_i[ADDR_W+1:2]     : cpu_addr_i[ADDR_W+1:2];
        wdata_d = pick_dbg_d ? dbg_wdata_i                : cpu_wdata_i;
    end

    // tmo_q is zero in the first BUSY cycle, so the watchdog fires after TIMEOUT+1 ready-less cycles.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_dbg_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            run_q       <= '0;
            tmo_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        owner_dbg_q <= pick_dbg_d;
                        we_q        <= we_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        run_q       <= run_d;
                        tmo_q       <= '0;
                        mem_en_q    <= 1'b1;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ready_i || tmo_hit) begin
                        if (mem_ready_i && !we_q) begin
                            if (owner_dbg_q) begin
                                dbg_rdata_q <= mem_rdata_i;
                            end else begin
                                cpu_rdata_q <= mem_rdata_i;
                            end
                        end
                        cpu_ack_q <= !owner_dbg_q;
                        dbg_ack_q <= owner_dbg_q;
                        err_q     <= !mem_ready_i;
                        mem_en_q  <= 1'b0;
                        state_q   <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side fields are zeroed outside the access window so the bus is quiet when idle.
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_en_q & we_q;
    assign mem_addr_o  = mem_en_q ? addr_q  : '0;
    assign mem_wdata_o = mem_en_q ? wdata_q : '0;

    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign err_o       = err_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] dbg_grant_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q     <= '0;
            dbg_grant_cnt_q <= '0;
        end else begin
            if (cpu_stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (grant_d && pick_dbg_d) begin
                dbg_grant_cnt_q <= dbg_grant_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o     = stall_cnt_q;
    assign dbg_grant_cnt_o = dbg_grant_cnt_q;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0],
                                dbg_addr_i[31:ADDR_W+2], dbg_addr_i[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a transaction-timing reference model
module tb_dmem_arbiter;

    localparam int ADDR_W      = 5;
    localparam int MAX_CPU_RUN = 4;
    localparam int TIMEOUT     = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ack_o, cpu_stall_o;
    logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o, err_o;
    logic        mem_en_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic        mem_ready_i = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_o, dbg_grant_cnt_o;
`endif

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_CPU_RUN(MAX_CPU_RUN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o), .err_o(err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
`ifdef DMEM_ARB_PERF_EN
        .stall_cnt_o(stall_cnt_o), .dbg_grant_cnt_o(dbg_grant_cnt_o),
`endif
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Environment memory (driven from DUT pins) and reference memory (driven by the model).
    logic [31:0] env_mem [32];
    logic [31:0] ref_mem [32];
    bit          mem_loaded = 1'b0;
    assign mem_rdata_i = env_mem[mem_addr_o];

    // Reference model: each access is a grant cycle g, a memory window g+1..e, an ack at e+1.
    int          cyc = 0, m_g = 0, m_free = 0, m_ack_cyc = -1, m_run = 0;
    bit          m_act = 0, m_own_dbg = 0, m_ack_dbg = 0, m_err = 0, m_we = 0, chk_en = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        exp_mem_en = 0, exp_mem_we = 0, exp_cpu_ack = 0, exp_dbg_ack = 0, exp_err = 0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_wdata = '0, exp_cpu_rdata = '0, exp_dbg_rdata = '0;
    logic [31:0] m_stall_cnt = '0, m_dbg_grants = '0;

    always @(posedge clk_i) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) begin
                env_mem[i] = (i == 0) ? 32'd5 : 32'h100 + 32'(i);
                ref_mem[i] = (i == 0) ? 32'd5 : 32'h100 + 32'(i);
            end
            mem_loaded = 1'b1;
        end else if (mem_en_o && mem_we_o && mem_ready_i) begin
            env_mem[mem_addr_o] = mem_wdata_o;
        end

        if (rst_i) begin
            m_act = 0; m_run = 0; m_free = cyc + 1; m_ack_cyc = -1;
            exp_cpu_rdata = '0; exp_dbg_rdata = '0;
            m_stall_cnt = '0; m_dbg_grants = '0;
            chk_en = 1;
        end else begin
            if (cpu_req_i && !exp_cpu_ack) m_stall_cnt = m_stall_cnt + 1;
            if (!m_act) begin
                if (cyc >= m_free && start_i && (cpu_req_i || dbg_req_i)) begin
                    m_own_dbg = dbg_req_i && (!cpu_req_i || m_run == MAX_CPU_RUN);
                    if (m_own_dbg || !dbg_req_i) m_run = 0;
                    else if (m_run < MAX_CPU_RUN) m_run = m_run + 1;
                    if (m_own_dbg) m_dbg_grants = m_dbg_grants + 1;
                    m_we    = m_own_dbg ? dbg_we_i : cpu_we_i;
                    m_addr  = 5'(((m_own_dbg ? dbg_addr_i : cpu_addr_i) >> 2) % 32);
                    m_wdata = m_own_dbg ? dbg_wdata_i : cpu_wdata_i;
                    m_act = 1; m_g = cyc;
                end
            end else if (mem_ready_i || (TIMEOUT != 0 && cyc - m_g == TIMEOUT + 1)) begin
                if (mem_ready_i) begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    else if (m_own_dbg) exp_dbg_rdata = ref_mem[m_addr];
                    else exp_cpu_rdata = ref_mem[m_addr];
                end
                m_act = 0; m_err = !mem_ready_i; m_ack_dbg = m_own_dbg;
                m_ack_cyc = cyc + 1; m_free = cyc + 2;
            end
        end
        cyc = cyc + 1;
        exp_mem_en  = m_act && cyc > m_g;
        exp_mem_we  = exp_mem_en && m_we;
        exp_addr    = exp_mem_en ? m_addr : 5'd0;
        exp_wdata   = exp_mem_en ? m_wdata : 32'd0;
        exp_cpu_ack = (cyc == m_ack_cyc) && !m_ack_dbg;
        exp_dbg_ack = (cyc == m_ack_cyc) && m_ack_dbg;
        exp_err     = (cyc == m_ack_cyc) && m_err;
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("mem_en",    32'(mem_en_o),    32'(exp_mem_en));
            chk("mem_we",    32'(mem_we_o),    32'(exp_mem_we));
            chk("mem_addr",  32'(mem_addr_o),  32'(exp_addr));
            chk("mem_wdata", mem_wdata_o,      exp_wdata);
            chk("cpu_ack",   32'(cpu_ack_o),   32'(exp_cpu_ack));
            chk("dbg_ack",   32'(dbg_ack_o),   32'(exp_dbg_ack));
            chk("err",       32'(err_o),       32'(exp_err));
            chk("cpu_rdata", cpu_rdata_o,      exp_cpu_rdata);
            chk("dbg_rdata", dbg_rdata_o,      exp_dbg_rdata);
            chk("cpu_stall", 32'(cpu_stall_o), 32'(cpu_req_i && !exp_cpu_ack));
`ifdef DMEM_ARB_PERF_EN
            chk("stall_cnt", stall_cnt_o,      m_stall_cnt);
            chk("dbg_grants", dbg_grant_cnt_o, m_dbg_grants);
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle(input int n);
        cpu_req_i = 0; dbg_req_i = 0; rst_i = 0; mem_ready_i = 0;
        repeat (n) next_cycle();
    endtask

    task automatic set_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
    endtask

    byte   seq [6];
    string exp_seq;
    int    n, rise, ackk, lvl;
    logic  err_seen;
    logic [31:0] rd_seen;

    initial begin
        rst_i = 1;
        repeat (3) next_cycle();
        rst_i = 0; start_i = 1;
        idle(2);

        // Single CPU read of word 0 with an always-ready memory.
        set_cpu(0, 32'h0, 32'h0); mem_ready_i = 1;
        @(negedge clk_i); chk("t1_stall_n0", 32'(cpu_stall_o), 32'd1);
        next_cycle();
        @(negedge clk_i); chk("t1_en_n1", 32'(mem_en_o), 32'd1); chk("t1_stall_n1", 32'(cpu_stall_o), 32'd1);
        next_cycle();
        @(negedge clk_i); chk("t1_ack_n2", 32'(cpu_ack_o), 32'd1); chk("t1_rdata", cpu_rdata_o, 32'd5);
        chk("t1_stall_n2", 32'(cpu_stall_o), 32'd0);
        next_cycle();
        idle(2);

        // CPU write with a memory that becomes ready in its 4th access cycle.
        set_cpu(1, 32'h8, 32'h1234); mem_ready_i = 0;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            mem_ready_i = (k == 4);
            @(negedge clk_i);
            chk("t2_we_held", 32'(mem_we_o), 32'd1);
            chk("t2_addr_held", 32'(mem_addr_o), 32'd2);
        end
        next_cycle();
        @(negedge clk_i); chk("t2_ack", 32'(cpu_ack_o), 32'd1);
        next_cycle();
        idle(1);
        chk("t2_word2", env_mem[2], 32'h1234);
        idle(1);

        // Both requesters continuously: debug is forced in on the 5th completion.
        set_cpu(0, 32'h0, 32'h0);
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 32'hC; dbg_wdata_i = 0; mem_ready_i = 1;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk_i);
            if (cpu_ack_o) begin seq[n] = "c"; n++; end
            else if (dbg_ack_o) begin seq[n] = "d"; n++; end
            next_cycle();
        end
        chk("t3_count", 32'(n), 32'd6);
        exp_seq = "ccccdc";
        for (int i = 0; i < n; i++) chk("t3_order", 32'(seq[i]), 32'(exp_seq[i]));
        idle(2);

        // Memory never ready: watchdog completes with error, rdata untouched.
        set_cpu(0, 32'h4, 32'h0); mem_ready_i = 0;
        rise = -1; ackk = -1; err_seen = 0; rd_seen = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (mem_en_o && rise < 0) rise = k;
            if (cpu_ack_o) begin ackk = k; err_seen = err_o; rd_seen = cpu_rdata_o; break; end
            next_cycle();
        end
        chk("t4_latency", 32'(ackk - rise), 32'd9);
        chk("t4_err", 32'(err_seen), 32'd1);
        chk("t4_rdata_kept", rd_seen, 32'd5);
        next_cycle();
        idle(2);

        // Reset in the middle of an access, request held across it.
        set_cpu(0, 32'h10, 32'h0); mem_ready_i = 0;
        next_cycle(); next_cycle();
        @(negedge clk_i); chk("t5_busy", 32'(mem_en_o), 32'd1);
        next_cycle(); rst_i = 1;
        next_cycle(); rst_i = 0;
        @(negedge clk_i); chk("t5_en_after_rst", 32'(mem_en_o), 32'd0); chk("t5_no_ack", 32'(cpu_ack_o), 32'd0);
        next_cycle(); mem_ready_i = 1;
        @(negedge clk_i); chk("t5_regrant", 32'(mem_en_o), 32'd1);
        next_cycle();
        @(negedge clk_i); chk("t5_ack", 32'(cpu_ack_o), 32'd1);
        next_cycle();
        idle(2);

        // start_i low blocks grants; ack two cycles after it rises.
        start_i = 0; set_cpu(0, 32'h0, 32'h0); mem_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("t6_no_en", 32'(mem_en_o), 32'd0); chk("t6_stall", 32'(cpu_stall_o), 32'd1);
            next_cycle();
        end
        start_i = 1;
        next_cycle(); next_cycle();
        @(negedge clk_i); chk("t6_ack", 32'(cpu_ack_o), 32'd1);
        next_cycle();
        idle(2);

        // Randomized traffic: requesters, start, readiness level and occasional resets.
        lvl = 8;
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            if (c % 64 == 0) lvl = $urandom_range(0, 8);
            if (cpu_req_i && exp_cpu_ack) begin
                cpu_req_i = ($urandom_range(0, 1) == 1);
                cpu_we_i = $urandom_range(0, 1); cpu_addr_i = $urandom; cpu_wdata_i = $urandom;
            end else if (cpu_req_i) begin
                if ($urandom_range(0, 39) == 0) cpu_req_i = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                set_cpu($urandom_range(0, 1), $urandom, $urandom);
            end
            if (dbg_req_i && exp_dbg_ack) begin
                dbg_req_i = ($urandom_range(0, 1) == 1);
                dbg_we_i = $urandom_range(0, 1); dbg_addr_i = $urandom; dbg_wdata_i = $urandom;
            end else if (dbg_req_i) begin
                if ($urandom_range(0, 39) == 0) dbg_req_i = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                dbg_req_i = 1; dbg_we_i = $urandom_range(0, 1); dbg_addr_i = $urandom; dbg_wdata_i = $urandom;
            end
            start_i = ($urandom_range(0, 7) != 0);
            rst_i = ($urandom_range(0, 299) == 0);
            mem_ready_i = !rst_i && ($urandom_range(0, 7) < lvl);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
